gmii_ptp_parser: RTL and testbench
==================================

GMII_PTP_PARSER -- requirements
Module: gmii_ptp_parser

Interface
REQ-001 SHALL have parameter EVENT_ONLY, default 1, meaning 1 reports only PTP event messages (messageType 0-3) and 0 reports all messageTypes.
REQ-002 SHALL have parameter UDP_EN, default 1, meaning 1 enables IPv4/UDP port-319 PTP detection and 0 restricts detection to Layer-2 PTP.
REQ-003 clk  input  1  GMII byte clock; the only clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 gmii_ctrl  input  1  GMII data-valid (RX_DV/TX_EN).
REQ-006 gmii_data  input  8  GMII data byte.
REQ-007 sfd_pulse  output  1  one-cycle strobe marking SFD, the timestamp capture point for the downstream timestamp unit.
REQ-008 ptp_valid  output  1  one-cycle strobe: a matching PTP message was parsed.
REQ-009 ptp_msg_type  output  4  messageType of the last reported message.
REQ-010 ptp_seq_id  output  16  sequenceId of the last reported message.
REQ-011 ptp_is_udp  output  1  1 means the last reported message was IPv4/UDP; 0 means Layer-2.
REQ-012 ptp_cnt  output  16  count of ptp_valid strobes, wrapping at 0xFFFF.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, BODY and DROP.
REQ-014 IDLE: ctrl=1 with data=0x55 -> PREAMBLE; ctrl=1 with any other data -> DROP; ctrl=0 -> stay.
REQ-015 PREAMBLE: ctrl=0 -> IDLE; data=0x55 -> stay; data=0xD5 -> BODY; any other data -> DROP.
REQ-016 sfd_pulse SHALL be high exactly one cycle, namely the cycle after 0xD5 is sampled in PREAMBLE.
REQ-017 BODY: 11-bit byte index, 0 at the first destination-MAC byte, +1 per sampled byte, saturating at 2047; ctrl=0 -> IDLE.
REQ-018 DROP: stay until ctrl=0, then -> IDLE; no outputs are generated.
REQ-019 Ethertype SHALL be sampled at index 12-13; value 0x8100 shifts all later offsets by +4 and re-samples the ethertype at 16-17. Only one VLAN tag is supported; a second 0x8100 means no match.
REQ-020 Layer-2 match: ethertype 0x88F7; PTP header start P=14 (18 with VLAN).
REQ-021 UDP match (UDP_EN=1 only), all of the following required:
- ethertype 0x0800;
- IP byte0 = 0x45 (IHL other than 5 means no match);
- IP byte9 = 17;
- UDP destination port (IP bytes 22-23) = 319;
- P = 42 (46 with VLAN).
REQ-022 PTP fields: messageType = low nibble of byte P; sequenceId = bytes P+30 (MSB) and P+31 (LSB).
REQ-023 ptp_valid SHALL assert one cycle after byte P+31 is sampled, if matched and messageType passes EVENT_ONLY.
REQ-024 ptp_msg_type, ptp_seq_id and ptp_is_udp SHALL update in the same cycle ptp_valid asserts, and hold until the next ptp_valid.
REQ-025 Frame ending (ctrl=0) before byte P+31: no ptp_valid; partially captured fields are discarded.
REQ-026 ctrl=0 for a single cycle ends the frame; the next ctrl=1 cycle is evaluated in IDLE.
REQ-027 Bytes after P+31 SHALL be ignored; at most one ptp_valid per frame.
REQ-028 ptp_cnt SHALL increment by 1 in the same cycle as ptp_valid; it wraps from 0xFFFF to 0.

Reset
REQ-029 While rst=1: state IDLE; byte index 0; all outputs 0; reset takes priority over all inputs.
REQ-030 rst asserted mid-frame SHALL abort the frame with no ptp_valid. After release, the state is IDLE, so the remainder of an in-progress frame goes to DROP.

Verification
REQ-031 L2 frame, 7x0x55 + 0xD5, ethertype 0x88F7, msgType 0, seq 0x1234 -> sfd_pulse 1 cycle after 0xD5; ptp_valid 1 cycle after index 45; msg_type 0, seq_id 0x1234, is_udp 0, ptp_cnt 1.
REQ-032 VLAN-tagged L2 frame, seq 0xBEEF -> ptp_valid 1 cycle after index 49; seq_id 0xBEEF.
REQ-033 IPv4/UDP frame, dst port 319, msgType 1, seq 0x0001 -> ptp_valid after index 73; is_udp 1. Same frame with port 320 -> no ptp_valid.
REQ-034 Follow_Up (msgType 8), EVENT_ONLY=1 -> no ptp_valid; with EVENT_ONLY=0 -> ptp_valid, msg_type 8.
REQ-035 L2 PTP frame truncated at index 40, then a valid frame after one idle cycle -> exactly one ptp_valid, for the second frame.
REQ-036 rst pulsed at index 30 of a PTP frame -> no ptp_valid, outputs 0; the tail goes to DROP; the next full frame is reported correctly.

Source files
------------

// File: rtl/gmii_ptp_parser.sv
// GMII receive-side PTP detector: marks SFD for timestamping and extracts
// messageType/sequenceId from Layer-2 or IPv4/UDP(319) PTP frames.
module gmii_ptp_parser #(
  parameter int EVENT_ONLY = 1,
  parameter int UDP_EN     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gmii_ctrl,
  input  logic [7:0]  gmii_data,
  output logic        sfd_pulse,
  output logic        ptp_valid,
  output logic [3:0]  ptp_msg_type,
  output logic [15:0] ptp_seq_id,
  output logic        ptp_is_udp,
  output logic [15:0] ptp_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_BODY, S_DROP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [10:0] r_idx;
  logic        r_vlan;
  logic [7:0]  r_et_hi;
  logic [15:0] r_etype;
  logic [7:0]  r_ip0;
  logic [7:0]  r_ip_proto;
  logic [7:0]  r_port_hi;
  logic [15:0] r_dport;
  logic [3:0]  r_msg;
  logic [7:0]  r_seq_hi;

  logic        w_byte;
  logic [10:0] w_off;
  logic [10:0] w_p;
  logic        w_is_ip;
  logic        w_l2_m;
  logic        w_udp_m;
  logic        w_type_ok;
  logic        w_hit;
  logic [15:0] w_et;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (gmii_ctrl) w_next = (gmii_data == 8'h55) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE: begin
        if (!gmii_ctrl)               w_next = S_IDLE;
        else if (gmii_data == 8'hD5)  w_next = S_BODY;
        else if (gmii_data != 8'h55)  w_next = S_DROP;
      end
      S_BODY:     if (!gmii_ctrl) w_next = S_IDLE;
      S_DROP:     if (!gmii_ctrl) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // All field offsets slide by 4 once a single VLAN tag has been seen.
  always_comb begin
    w_byte    = (r_state == S_BODY) && gmii_ctrl;
    w_off     = r_vlan ? 11'd4 : 11'd0;
    w_is_ip   = (r_etype == 16'h0800);
    w_p       = (w_is_ip ? 11'd42 : 11'd14) + w_off;
    w_l2_m    = (r_etype == 16'h88F7);
    w_udp_m   = (UDP_EN != 0) && w_is_ip && (r_ip0 == 8'h45) &&
                (r_ip_proto == 8'd17) && (r_dport == 16'd319);
    w_type_ok = (EVENT_ONLY == 0) || (r_msg[3:2] == 2'b00);
    w_hit     = w_byte && (r_idx == w_p + 11'd31) && (w_l2_m || w_udp_m) && w_type_ok;
    w_et      = {r_et_hi, gmii_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_vlan       <= 1'b0;
      r_et_hi      <= '0;
      r_etype      <= '0;
      r_ip0        <= '0;
      r_ip_proto   <= '0;
      r_port_hi    <= '0;
      r_dport      <= '0;
      r_msg        <= '0;
      r_seq_hi     <= '0;
      sfd_pulse    <= 1'b0;
      ptp_valid    <= 1'b0;
      ptp_msg_type <= '0;
      ptp_seq_id   <= '0;
      ptp_is_udp   <= 1'b0;
      ptp_cnt      <= '0;
    end else begin
      sfd_pulse <= (r_state == S_PREAMBLE) && gmii_ctrl && (gmii_data == 8'hD5);
      ptp_valid <= w_hit;
      if (r_state == S_PREAMBLE) begin
        r_idx      <= '0;
        r_vlan     <= 1'b0;
        r_etype    <= '0;
        r_ip0      <= '0;
        r_ip_proto <= '0;
        r_dport    <= '0;
        r_msg      <= '0;
      end else if (w_byte) begin
        if (r_idx != '1) r_idx <= r_idx + 11'd1;
        if (r_idx == 11'd12 + w_off) r_et_hi <= gmii_data;
        // A second 0x8100 lands in r_etype and so matches nothing.
        if (r_idx == 11'd13 + w_off) begin
          if ((w_et == 16'h8100) && !r_vlan) r_vlan  <= 1'b1;
          else                               r_etype <= w_et;
        end
        if (r_idx == 11'd14 + w_off) r_ip0      <= gmii_data;
        if (r_idx == 11'd23 + w_off) r_ip_proto <= gmii_data;
        if (r_idx == 11'd36 + w_off) r_port_hi  <= gmii_data;
        if (r_idx == 11'd37 + w_off) r_dport    <= {r_port_hi, gmii_data};
        if (r_idx == w_p)            r_msg      <= gmii_data[3:0];
        if (r_idx == w_p + 11'd30)   r_seq_hi   <= gmii_data;
      end
      if (w_hit) begin
        ptp_msg_type <= r_msg;
        ptp_seq_id   <= {r_seq_hi, gmii_data};
        ptp_is_udp   <= w_udp_m;
        ptp_cnt      <= ptp_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gmii_ptp_parser.sv
// Bench for gmii_ptp_parser: three parameter variants share one GMII stream,
// expectations come from a frame-level model evaluated on each whole burst.
module tb_gmii_ptp_parser;

  localparam int NCYC = 65536;
  localparam bit [2:0] EO = 3'b101;
  localparam bit [2:0] UE = 3'b011;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl;
  logic [7:0]  data;
  logic        o_sfd   [3];
  logic        o_valid [3];
  logic [3:0]  o_mt    [3];
  logic [15:0] o_seq   [3];
  logic        o_udp   [3];
  logic [15:0] o_cnt   [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  bit          exp_sfd [NCYC];
  bit          exp_rst [NCYC];
  bit [2:0]    exp_v   [NCYC];
  logic [3:0]  exp_mt  [NCYC];
  logic [15:0] exp_seq [NCYC];
  bit          exp_udp [NCYC];

  logic [3:0]  h_mt  [3] = '{default: '0};
  logic [15:0] h_seq [3] = '{default: '0};
  logic        h_udp [3] = '{default: '0};
  logic [15:0] h_cnt [3] = '{default: '0};

  logic [7:0] fq[$];
  int l_s, l_vpos;

  gmii_ptp_parser #(.EVENT_ONLY(1), .UDP_EN(1)) u0 (
    .clk(clk), .rst(rst), .gmii_ctrl(ctrl), .gmii_data(data),
    .sfd_pulse(o_sfd[0]), .ptp_valid(o_valid[0]), .ptp_msg_type(o_mt[0]),
    .ptp_seq_id(o_seq[0]), .ptp_is_udp(o_udp[0]), .ptp_cnt(o_cnt[0]));
  gmii_ptp_parser #(.EVENT_ONLY(0), .UDP_EN(1)) u1 (
    .clk(clk), .rst(rst), .gmii_ctrl(ctrl), .gmii_data(data),
    .sfd_pulse(o_sfd[1]), .ptp_valid(o_valid[1]), .ptp_msg_type(o_mt[1]),
    .ptp_seq_id(o_seq[1]), .ptp_is_udp(o_udp[1]), .ptp_cnt(o_cnt[1]));
  gmii_ptp_parser #(.EVENT_ONLY(1), .UDP_EN(0)) u2 (
    .clk(clk), .rst(rst), .gmii_ctrl(ctrl), .gmii_data(data),
    .sfd_pulse(o_sfd[2]), .ptp_valid(o_valid[2]), .ptp_msg_type(o_mt[2]),
    .ptp_seq_id(o_seq[2]), .ptp_is_udp(o_udp[2]), .ptp_cnt(o_cnt[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input int i,
                     input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", nm, d, i, act, exp);
    end
  endtask

  function automatic logic [7:0] bb(input logic [7:0] b[$], input int k);
    return (k < b.size()) ? b[k] : 8'h00;
  endfunction

  // Frame-level model: s = burst position of the SFD byte, vpos = burst
  // position of byte P+31, hit = which of the three variants report it.
  function automatic void eval(input logic [7:0] b[$], output int s, output int vpos,
                               output logic [3:0] m, output logic [15:0] sq,
                               output bit u, output bit [2:0] hit);
    int n, i, off, p, o;
    logic [15:0] et;
    logic [7:0] t;
    bit l2, um;
    s = -1; vpos = -1; m = '0; sq = '0; u = 1'b0; hit = '0;
    n = b.size();
    if (n == 0 || b[0] != 8'h55) return;
    i = 1;
    while (i < n && b[i] == 8'h55) i++;
    if (i >= n || b[i] != 8'hD5) return;
    s = i;
    o = s + 1;
    off = 0;
    et = {bb(b, o + 12), bb(b, o + 13)};
    if (et == 16'h8100) begin
      off = 4;
      et = {bb(b, o + 16), bb(b, o + 17)};
      if (et == 16'h8100) return;
    end
    l2 = (et == 16'h88F7);
    um = (et == 16'h0800) && (bb(b, o + 14 + off) == 8'h45) && (bb(b, o + 23 + off) == 8'd17) &&
         ({bb(b, o + 36 + off), bb(b, o + 37 + off)} == 16'd319);
    p = (l2 ? 14 : 42) + off;
    if (!(l2 || um) || (n - o) < p + 32) return;
    vpos = o + p + 31;
    t = bb(b, o + p);
    m = t[3:0];
    sq = {bb(b, o + p + 30), bb(b, o + p + 31)};
    u = um;
    for (int d = 0; d < 3; d++)
      hit[d] = (l2 || (um && UE[d])) && (!EO[d] || m < 4'd4);
  endfunction

  task automatic post(input int base, input logic [7:0] b[$]);
    int s, vp; logic [3:0] m; logic [15:0] sq; bit u; bit [2:0] hit;
    eval(b, s, vp, m, sq, u, hit);
    l_s = s; l_vpos = vp;
    if (s >= 0) exp_sfd[base + s] = 1'b1;
    if (hit != 0) begin
      exp_v[base + vp] = hit; exp_mt[base + vp] = m;
      exp_seq[base + vp] = sq; exp_udp[base + vp] = u;
    end
  endtask

  task automatic send(input int rpos, input int gap);
    int base, ls, lv;
    logic [7:0] part[$];
    @(negedge clk);
    base = cyc;
    if (rpos < 0) post(base, fq);
    else begin
      for (int k = 0; k < rpos; k++) part.push_back(fq[k]);
      post(base, part);
      ls = l_s; lv = l_vpos;
      exp_rst[base + rpos] = 1'b1;
      part.delete();
      for (int k = rpos + 1; k < fq.size(); k++) part.push_back(fq[k]);
      post(base + rpos + 1, part);
      l_s = ls; l_vpos = lv;
    end
    for (int k = 0; k < fq.size(); k++) begin
      if (k > 0) @(negedge clk);
      ctrl = 1'b1; data = fq[k]; rst = (k == rpos);
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      ctrl = 1'b0; rst = 1'b0; data = 8'($urandom);
    end
  endtask

  task automatic push_rnd(input int n);
    repeat (n) fq.push_back(8'($urandom));
  endtask

  task automatic head(input int pre, input int nv);
    fq.delete();
    repeat (pre) fq.push_back(8'h55);
    fq.push_back(8'hD5);
    push_rnd(12);
    repeat (nv) begin fq.push_back(8'h81); fq.push_back(8'h00); push_rnd(2); end
  endtask

  task automatic push_ptp(input logic [3:0] m, input logic [15:0] sq);
    fq.push_back({4'($urandom), m});
    push_rnd(29);
    fq.push_back(sq[15:8]); fq.push_back(sq[7:0]);
    push_rnd($urandom_range(0, 6));
  endtask

  task automatic build_l2(input int pre, input int nv, input logic [3:0] m, input logic [15:0] sq);
    head(pre, nv);
    fq.push_back(8'h88); fq.push_back(8'hF7);
    push_ptp(m, sq);
  endtask

  task automatic build_udp(input int pre, input int nv, input logic [3:0] m, input logic [15:0] sq,
                           input logic [15:0] port, input logic [7:0] ihl, input logic [7:0] proto);
    head(pre, nv);
    fq.push_back(8'h08); fq.push_back(8'h00);
    fq.push_back(ihl); push_rnd(8); fq.push_back(proto); push_rnd(10);
    push_rnd(2); fq.push_back(port[15:8]); fq.push_back(port[7:0]); push_rnd(4);
    push_ptp(m, sq);
  endtask

  always @(negedge clk) begin : cmp
    int i;
    if (cyc > 0) begin
      i = cyc - 1;
      for (int d = 0; d < 3; d++) begin
        if (exp_rst[i]) begin
          h_mt[d] = '0; h_seq[d] = '0; h_udp[d] = 1'b0; h_cnt[d] = '0;
        end else if (exp_v[i][d]) begin
          h_mt[d] = exp_mt[i]; h_seq[d] = exp_seq[i]; h_udp[d] = exp_udp[i];
          h_cnt[d] = h_cnt[d] + 16'd1;
        end
        chk("sfd_pulse",    d, i, 16'(o_sfd[d]),   16'(exp_sfd[i]));
        chk("ptp_valid",    d, i, 16'(o_valid[d]), 16'(exp_v[i][d]));
        chk("ptp_msg_type", d, i, 16'(o_mt[d]),    16'(h_mt[d]));
        chk("ptp_seq_id",   d, i, o_seq[d],        h_seq[d]);
        chk("ptp_is_udp",   d, i, 16'(o_udp[d]),   16'(h_udp[d]));
        chk("ptp_cnt",      d, i, o_cnt[d],        h_cnt[d]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int kind, pre, nv, len, rp;
    logic [3:0] m;
    rst = 1'b1; ctrl = 1'b0; data = 8'h00;
    for (int k = 0; k < 4; k++) exp_rst[k] = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    build_l2(7, 0, 4'd0, 16'h1234);
    send(-1, 2); #1;
    chk("model_sfd_pos", 0, -1, 16'(l_s), 16'd7);
    chk("model_l2_pos", 0, -1, 16'(l_vpos), 16'd53);
    chk("l2_seq", 0, -1, o_seq[0], 16'h1234);
    chk("l2_type", 0, -1, 16'(o_mt[0]), 16'd0);
    chk("l2_udp", 0, -1, 16'(o_udp[0]), 16'd0);
    chk("l2_cnt", 0, -1, o_cnt[0], 16'd1);

    build_l2(7, 1, 4'd2, 16'hBEEF);
    send(-1, 1); #1;
    chk("model_vlan_pos", 0, -1, 16'(l_vpos), 16'd57);
    chk("vlan_seq", 0, -1, o_seq[0], 16'hBEEF);
    chk("vlan_cnt", 0, -1, o_cnt[0], 16'd2);

    build_udp(7, 0, 4'd1, 16'h0001, 16'd319, 8'h45, 8'd17);
    send(-1, 3); #1;
    chk("model_udp_pos", 0, -1, 16'(l_vpos), 16'd81);
    chk("udp_is_udp", 0, -1, 16'(o_udp[0]), 16'd1);
    chk("udp_seq", 0, -1, o_seq[0], 16'h0001);
    chk("udp_cnt", 0, -1, o_cnt[0], 16'd3);
    chk("udp_off_cnt", 2, -1, o_cnt[2], 16'd2);

    build_udp(7, 0, 4'd1, 16'h0002, 16'd320, 8'h45, 8'd17);
    send(-1, 1); #1;
    chk("port320_cnt", 0, -1, o_cnt[0], 16'd3);

    build_l2(7, 0, 4'd8, 16'h5555);
    send(-1, 1); #1;
    chk("fup_event_cnt", 0, -1, o_cnt[0], 16'd3);
    chk("fup_all_type", 1, -1, 16'(o_mt[1]), 16'd8);
    chk("fup_all_cnt", 1, -1, o_cnt[1], 16'd4);

    build_l2(7, 0, 4'd0, 16'hAAAA);
    while (fq.size() > 49) void'(fq.pop_back());
    send(-1, 1);
    build_l2(7, 0, 4'd0, 16'h7777);
    send(-1, 2); #1;
    chk("trunc_cnt", 0, -1, o_cnt[0], 16'd4);
    chk("trunc_seq", 0, -1, o_seq[0], 16'h7777);

    build_l2(7, 0, 4'd0, 16'h9999);
    fq[39] = 8'h11;
    send(38, 2); #1;
    chk("rst_cnt", 0, -1, o_cnt[0], 16'd0);
    chk("rst_seq", 0, -1, o_seq[0], 16'd0);
    build_l2(7, 0, 4'd3, 16'h4321);
    send(-1, 1); #1;
    chk("post_rst_cnt", 0, -1, o_cnt[0], 16'd1);
    chk("post_rst_seq", 0, -1, o_seq[0], 16'h4321);
    chk("post_rst_type", 0, -1, 16'(o_mt[0]), 16'd3);

    build_l2(7, 2, 4'd0, 16'h2222);
    send(-1, 1); #1;
    chk("dbl_vlan_cnt", 0, -1, o_cnt[0], 16'd1);

    for (int fr = 0; fr < 300 && cyc < NCYC - 300; fr++) begin
      kind = $urandom_range(0, 9);
      pre  = $urandom_range(1, 8);
      nv   = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      m    = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      if (kind < 4) build_l2(pre, nv, m, 16'($urandom));
      else if (kind < 8)
        build_udp(pre, nv, m, 16'($urandom),
                  ($urandom_range(0, 4) == 0) ? 16'd320 : 16'd319,
                  ($urandom_range(0, 5) == 0) ? 8'h46 : 8'h45,
                  ($urandom_range(0, 5) == 0) ? 8'd6 : 8'd17);
      else begin
        fq.delete();
        len = $urandom_range(1, 60);
        if ($urandom_range(0, 1) != 0) fq.push_back(8'h55);
        push_rnd(len);
      end
      if ($urandom_range(0, 3) == 0) fq[$urandom_range(0, fq.size() - 1)] = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        len = $urandom_range(1, fq.size());
        while (fq.size() > len) void'(fq.pop_back());
      end
      rp = ($urandom_range(0, 9) == 0 && fq.size() > 1) ? int'($urandom_range(1, fq.size() - 1)) : -1;
      send(rp, $urandom_range(1, 3));
    end

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
